// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps the DDS frequency word from a start to a stop word with a per-point
// dwell, in single, repeat or up-down (triangle) modes; forwards the configured phase word.
module dds_sweep_ctrl #(
  parameter int PHASE_WIDTH = 32,
  parameter int DWELL_WIDTH = 24
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] cfg_start_word,
  input  logic [PHASE_WIDTH-1:0] cfg_stop_word,
  input  logic [PHASE_WIDTH-1:0] cfg_step_word,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic [1:0]             cfg_mode,
  input  logic [PHASE_WIDTH-1:0] cfg_pha_word,
  input  logic                   start,
  input  logic                   abort,
  output logic [PHASE_WIDTH-1:0] fre_word,
  output logic [PHASE_WIDTH-1:0] pha_word,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            sweep_cnt
);
  localparam int W = PHASE_WIDTH;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [W-1:0] start_q, stop_q, step_q, pha_q, fre_q, fre_d;
  logic [W-1:0] e_start, e_stop, e_step, tgt;
  logic [DWELL_WIDTH-1:0] dwell_q, cnt_q, cnt_d, e_dwell;
  logic [1:0] mode_q;
  logic [15:0] scnt_q, scnt_d;
  logic up_q, up_d, back_q, back_d, degen_q, degen_d, done_q, done_d;
  logic accept, at_end;

  // One step toward t, computed one bit wider so a pass beyond t (or a borrow) clamps to t.
  function automatic logic [W-1:0] advance(input logic [W-1:0] f, s, t, input logic up);
    logic [W:0] n;
    n = up ? {1'b0, f} + {1'b0, s} : {1'b0, f} - {1'b0, s};
    if (up) return n >= {1'b0, t} ? t : n[W-1:0];
    return (n[W] || n[W-1:0] <= t) ? t : n[W-1:0];
  endfunction

  assign accept  = cfg_valid && state_q == IDLE;
  assign e_start = accept ? cfg_start_word : start_q;
  assign e_stop  = accept ? cfg_stop_word : stop_q;
  assign e_step  = accept ? cfg_step_word : step_q;
  assign e_dwell = accept ? cfg_dwell : dwell_q;
  // back_q is set on the return leg of an up-down sweep, where start becomes the target.
  assign tgt     = back_q ? start_q : stop_q;
  assign at_end  = degen_q || fre_q == tgt;

  always_comb begin
    state_d = state_q;
    fre_d   = fre_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    up_d    = up_q;
    back_d  = back_q;
    degen_d = degen_q;
    done_d  = 1'b0;
    if (abort) state_d = IDLE;
    else if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        fre_d   = e_start;
        cnt_d   = e_dwell;
        scnt_d  = '0;
        up_d    = e_start <= e_stop;
        back_d  = 1'b0;
        degen_d = e_step == '0 || e_start == e_stop;
      end
    end else if (cnt_q != '0) cnt_d = cnt_q - DWELL_WIDTH'(1);
    else begin
      cnt_d = dwell_q;
      if (!at_end) fre_d = advance(fre_q, step_q, tgt, up_q);
      else begin
        scnt_d = scnt_q + 16'd1;
        if (mode_q == 2'd1) fre_d = start_q;
        else if (mode_q == 2'd2) begin
          back_d = !back_q;
          up_d   = !up_q;
          fre_d  = degen_q ? fre_q : advance(fre_q, step_q, back_q ? stop_q : start_q, !up_q);
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      mode_q  <= '0;
      pha_q   <= '0;
      fre_q   <= '0;
      cnt_q   <= '0;
      scnt_q  <= '0;
      up_q    <= 1'b0;
      back_q  <= 1'b0;
      degen_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (accept) begin
        start_q <= cfg_start_word;
        stop_q  <= cfg_stop_word;
        step_q  <= cfg_step_word;
        dwell_q <= cfg_dwell;
        mode_q  <= cfg_mode;
        pha_q   <= cfg_pha_word;
      end
      state_q <= state_d;
      fre_q   <= fre_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      up_q    <= up_d;
      back_q  <= back_d;
      degen_q <= degen_d;
      done_q  <= done_d;
    end
  end

  assign cfg_ready = state_q == IDLE;
  assign busy      = state_q == RUN;
  assign fre_word  = fre_q;
  assign pha_word  = pha_q;
  assign done      = done_q;
  assign sweep_cnt = scnt_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: expected per-cycle outputs are built from the sweep point lists and queued;
// a monitor on the falling edge pops one entry per cycle and compares it with the DUT.
module tb_dds_sweep_ctrl;
  logic clock = 1'b0, reset;
  logic cfg_valid, cfg_ready, start, abort, busy, done;
  logic [31:0] cfg_start_word, cfg_stop_word, cfg_step_word, cfg_pha_word, fre_word, pha_word;
  logic [23:0] cfg_dwell;
  logic [1:0] cfg_mode;
  logic [15:0] sweep_cnt;

  typedef struct packed {
    logic [31:0] fre;
    logic [31:0] pha;
    logic [15:0] cnt;
    logic busy, done, rdy;
  } rec_t;

  rec_t exq[$];
  longint unsigned seg[$];
  int n_cmp = 0, n_bad = 0;
  string tag = "init";
  logic [31:0] cur_start, cur_stop, cur_step, cur_pha, m_fre;
  logic [23:0] cur_dwell;
  logic [1:0] cur_mode;
  logic [15:0] m_cnt;

  dds_sweep_ctrl dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start_word(cfg_start_word), .cfg_stop_word(cfg_stop_word),
    .cfg_step_word(cfg_step_word), .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
    .cfg_pha_word(cfg_pha_word), .start(start), .abort(abort), .fre_word(fre_word),
    .pha_word(pha_word), .busy(busy), .done(done), .sweep_cnt(sweep_cnt)
  );

  always #5 clock = ~clock;

  function automatic rec_t mk(input logic [31:0] f, input logic [15:0] c, input logic b, d, y);
    rec_t x;
    x.fre = f; x.pha = cur_pha; x.cnt = c; x.busy = b; x.done = d; x.rdy = y;
    return x;
  endfunction

  function automatic rec_t dut_out();
    rec_t x;
    x.fre = fre_word; x.pha = pha_word; x.cnt = sweep_cnt; x.busy = busy; x.done = done; x.rdy = cfg_ready;
    return x;
  endfunction

  // Points visited from a to b: steps of s, last one clamped onto b.
  function automatic void gen(input longint unsigned a, b, s);
    longint unsigned v;
    seg.delete();
    seg.push_back(a);
    if (s == 0 || a == b) return;
    v = a;
    while (v != b) begin
      if (b > a) v = (v + s >= b) ? b : v + s;
      else v = (v <= b + s) ? b : v - s;
      seg.push_back(v);
    end
  endfunction

  task automatic cmp(input string nm, input rec_t a, input rec_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got fre=%h pha=%h cnt=%0d busy=%b done=%b rdy=%b, want fre=%h pha=%h cnt=%0d busy=%b done=%b rdy=%b",
               nm, $time, a.fre, a.pha, a.cnt, a.busy, a.done, a.rdy, e.fre, e.pha, e.cnt, e.busy, e.done, e.rdy);
    end
  endtask

  always @(negedge clock) if (exq.size() > 0) cmp(tag, dut_out(), exq.pop_front());

  task automatic idle(input int n);
    repeat (n) exq.push_back(mk(m_fre, m_cnt, 1'b0, 1'b0, 1'b1));
    repeat (n) @(posedge clock);
    #1;
  endtask

  // ab>0: abort sampled on the ab-th edge after the start edge. nw=0 reuses the stored config.
  task automatic sweep(input string nm, input logic [31:0] s0, s1, st, input logic [23:0] dw,
                       input logic [1:0] md, input logic [31:0] ph, input bit nw,
                       input int ncyc, input int ab, input bit poke);
    rec_t r[$];
    int k;
    logic [15:0] c;
    bit single, degen;
    tag = nm;
    if (nw) begin
      cur_start = s0; cur_stop = s1; cur_step = st; cur_dwell = dw; cur_mode = md; cur_pha = ph;
    end
    single = cur_mode == 2'd0 || cur_mode == 2'd3;
    degen = cur_step == 0 || cur_start == cur_stop;
    if (!single && (ab <= 0 || ab >= ncyc)) ab = ncyc - 1;
    cfg_start_word = s0; cfg_stop_word = s1; cfg_step_word = st; cfg_dwell = dw;
    cfg_mode = md; cfg_pha_word = ph; cfg_valid = nw; start = 1'b1;
    @(posedge clock);
    #1;
    cfg_valid = 1'b0; start = 1'b0;
    c = 0; k = 0;
    while (single || r.size() < ncyc) begin
      if (degen) begin
        seg.delete();
        seg.push_back(longint'(cur_start));
      end else begin
        if (cur_mode == 2'd2 && k % 2 == 1) gen(cur_stop, cur_start, cur_step);
        else gen(cur_start, cur_stop, cur_step);
        if (cur_mode == 2'd2 && k > 0) void'(seg.pop_front());
      end
      foreach (seg[j]) repeat (int'(cur_dwell) + 1) r.push_back(mk(32'(seg[j]), c, 1'b1, 1'b0, 1'b0));
      c++;
      if (single) begin
        r.push_back(mk(r[$].fre, c, 1'b0, 1'b1, 1'b1));
        repeat (2) r.push_back(mk(r[$].fre, c, 1'b0, 1'b0, 1'b1));
        break;
      end
      k++;
    end
    while (!single && r.size() > ncyc) void'(r.pop_back());
    if (ab > 0 && ab < r.size())
      for (int j = ab; j < r.size(); j++) r[j] = mk(r[ab-1].fre, r[ab-1].cnt, 1'b0, 1'b0, 1'b1);
    foreach (r[j]) exq.push_back(r[j]);
    foreach (r[i]) begin
      abort = ab > 0 && i == ab - 1;
      cfg_valid = poke && r[i].busy;
      start = poke && r[i].busy && 1'($urandom);
      if (cfg_valid) begin
        cfg_start_word = $urandom; cfg_stop_word = $urandom; cfg_step_word = $urandom;
        cfg_dwell = 24'($urandom); cfg_mode = 2'($urandom); cfg_pha_word = $urandom;
      end
      @(posedge clock);
      #1;
    end
    abort = 1'b0; cfg_valid = 1'b0; start = 1'b0;
    m_fre = r[$].fre;
    m_cnt = r[$].cnt;
  endtask

  initial begin
    logic [31:0] base;
    int nc;
    reset = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_start_word = 0; cfg_stop_word = 0; cfg_step_word = 0; cfg_dwell = 0;
    cfg_mode = 0; cfg_pha_word = 0;
    cur_start = 0; cur_stop = 0; cur_step = 0; cur_dwell = 0; cur_mode = 0; cur_pha = 0;
    m_fre = 0; m_cnt = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    tag = "reset_state";
    idle(2);
    sweep("single_up", 100, 130, 10, 2, 0, 32'h1234, 1, 0, 0, 1);
    sweep("abort_110", 100, 130, 10, 2, 0, 32'h5678, 1, 0, 4, 1);
    tag = "start_abort_idle";
    start = 1'b1; abort = 1'b1;
    exq.push_back(mk(m_fre, m_cnt, 1'b0, 1'b0, 1'b1));
    exq.push_back(mk(m_fre, m_cnt, 1'b0, 1'b0, 1'b1));
    @(posedge clock);
    #1 start = 1'b0; abort = 1'b0;
    @(posedge clock);
    #1;
    sweep("clamp_up", 100, 125, 10, 0, 0, 32'h9, 1, 0, 0, 0);
    sweep("down", 130, 100, 20, 1, 3, 32'hA, 1, 0, 0, 1);
    sweep("overflow", 32'hFFFFFFF0, 32'hFFFFFFFF, 32'h20, 0, 0, 32'hB, 1, 0, 0, 0);
    sweep("updown", 0, 10, 5, 0, 2, 32'hC, 1, 24, 0, 1);
    sweep("updown_clamp", 100, 125, 10, 1, 2, 32'hD, 1, 40, 0, 0);
    sweep("degen_repeat", 77, 500, 0, 2, 1, 32'hE, 1, 15, 0, 1);
    sweep("shadow_reuse", 1, 2, 3, 4, 0, 32'hF, 0, 12, 0, 0);
    sweep("degen_updown", 40, 40, 3, 1, 2, 32'h10, 1, 10, 0, 0);
    tag = "reset_mid";
    cfg_start_word = 5000; cfg_stop_word = 5300; cfg_step_word = 7; cfg_dwell = 1;
    cfg_mode = 1; cfg_pha_word = 32'h77; cfg_valid = 1'b1; start = 1'b1;
    @(posedge clock);
    #1 cfg_valid = 1'b0; start = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    cur_start = 0; cur_stop = 0; cur_step = 0; cur_dwell = 0; cur_mode = 0; cur_pha = 0;
    m_fre = 0; m_cnt = 0;
    #1 cmp("reset_mid", dut_out(), mk(0, 0, 1'b0, 1'b0, 1'b1));
    @(posedge clock);
    #1 reset = 1'b0;
    idle(2);
    sweep("zero_shadow", 9, 9, 9, 9, 1, 32'h9, 0, 0, 0, 0);
    for (int it = 0; it < 40; it++) begin
      base = ($urandom % 4 == 0) ? 32'hFFFFFF00 : 32'h0;
      nc = $urandom_range(5, 60);
      sweep($sformatf("rand%0d", it), base + $urandom_range(0, 200), base + $urandom_range(0, 200),
            ($urandom % 6 == 0) ? 32'h0 : $urandom_range(1, 70), 24'($urandom_range(0, 3)),
            2'($urandom), $urandom, $urandom % 4 != 0, nc,
            ($urandom % 3 == 0) ? $urandom_range(1, nc - 1) : 0, 1'($urandom));
      if ($urandom % 3 == 0) idle(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
